run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 72 +++++++
 tb/tb_run_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: holds a downstream design in reset for a programmed number of cycles,
// then clock-enables it for a programmed run length and parks it for inspection.
module run_sequencer #(
    parameter int CNT_W  = 16,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0]  run_cycles,
    output logic              dut_reset_n,
    output logic              dut_clk_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2, DONE = 2'd3;
    logic [1:0] state, nxt, sync;
    logic [HOLD_W-1:0] hold_left;
    logic [CNT_W-1:0] run_len, cnt_inc;
    logic active, accept;
    assign active  = state == HOLD || state == RUN;
    assign accept  = sync[1] && start && !active;
    assign cnt_inc = cycle_count + CNT_W'(1);
    always_comb begin
        nxt = state;
        case (state)
            HOLD:    nxt = abort ? DONE : hold_left == HOLD_W'(1) ? (run_len != '0 ? RUN : DONE) : HOLD;
            RUN:     nxt = (abort || cnt_inc == run_len) ? DONE : RUN;
            default: nxt = accept ? HOLD : state;
        endcase
    end
    // release of reset_n is synchronised; assertion acts immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], 1'b1};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hold_left   <= '0;
            run_len     <= '0;
            cycle_count <= '0;
            aborted     <= 1'b0;
            dut_reset_n <= 1'b0;
            dut_clk_en  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= nxt;
            dut_reset_n <= nxt == RUN || nxt == DONE;
            dut_clk_en  <= nxt == RUN;
            busy        <= nxt == HOLD || nxt == RUN;
            done        <= nxt == DONE;
            if (accept) begin
                hold_left   <= hold_cycles == '0 ? HOLD_W'(1) : hold_cycles;
                run_len     <= run_cycles;
                cycle_count <= '0;
                aborted     <= 1'b0;
            end else if (active && abort) begin
                aborted <= 1'b1;
            end else if (state == HOLD) begin
                hold_left <= hold_left - HOLD_W'(1);
            end else if (state == RUN) begin
                cycle_count <= cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: table-driven sequence checks plus directed reset/abort/start corner cases.
module tb_run_sequencer;
    localparam int CW = 8, HW = 4;
    logic clk = 0, reset_n = 0, start = 0, abort = 0;
    logic [HW-1:0] hold_cycles = '0;
    logic [CW-1:0] run_cycles = '0;
    logic dut_reset_n, dut_clk_en, busy, done, aborted;
    logic [CW-1:0] cycle_count;
    int n_chk = 0, n_fail = 0;

    run_sequencer #(.CNT_W(CW), .HOLD_W(HW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .hold_cycles(hold_cycles), .run_cycles(run_cycles),
        .dut_reset_n(dut_reset_n), .dut_clk_en(dut_clk_en), .busy(busy),
        .done(done), .aborted(aborted), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int r; int ab;
        int e_hl; int e_cl; int e_lat; int e_cnt; int e_ab;
    } vec_t;
    vec_t v[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " dut_reset_n"}, int'(dut_reset_n), 0);
        chk({nm, " dut_clk_en"}, int'(dut_clk_en), 0);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " done"}, int'(done), 0);
        chk({nm, " aborted"}, int'(aborted), 0);
        chk({nm, " cycle_count"}, int'(cycle_count), 0);
    endtask

    // Accepts a start at edge k, then keeps start high with different lengths while busy
    // to show those are ignored; aborts when cycle_count reaches ab (ab<0: never).
    task automatic run_seq(input string nm, input int h, input int r, input int ab,
                           input int e_hl, input int e_cl, input int e_lat, input int e_cnt, input int e_ab);
        int hl, cl, lat;
        hl = 0; cl = 0; lat = 0;
        @(negedge clk);
        hold_cycles = HW'(h); run_cycles = CW'(r); start = 1;
        @(posedge clk);
        #1 hold_cycles = HW'(7); run_cycles = CW'(99);
        @(negedge clk);
        chk({nm, " cleared aborted"}, int'(aborted), 0);
        chk({nm, " cleared count"}, int'(cycle_count), 0);
        while (!done && lat < 400) begin
            lat++;
            if (busy && !dut_reset_n) hl++;
            if (dut_clk_en) cl++;
            abort = ab >= 0 && dut_clk_en && int'(cycle_count) == ab;
            @(negedge clk);
        end
        start = 0; abort = 0;
        chk({nm, " reached done"}, int'(done), 1);
        chk({nm, " hold cycles"}, hl, e_hl);
        chk({nm, " run cycles"}, cl, e_cl);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " cycle_count"}, int'(cycle_count), e_cnt);
        chk({nm, " aborted"}, int'(aborted), e_ab);
        chk({nm, " done clk_en"}, int'(dut_clk_en), 0);
        chk({nm, " done dut_reset_n"}, int'(dut_reset_n), 1);
        chk({nm, " done busy"}, int'(busy), 0);
    endtask

    initial begin
        //      h   r   ab  hl  cl  lat  cnt ab
        v[0] = '{2,  5, -1, 2,  5,  7,   5, 0};
        v[1] = '{0,  3, -1, 1,  3,  4,   3, 0};
        v[2] = '{4,  0, -1, 4,  0,  4,   0, 0};
        v[3] = '{1, 10,  3, 1,  4,  5,   3, 1};
        v[4] = '{3,  2, -1, 3,  2,  5,   2, 0};
        v[5] = '{1,  1, -1, 1,  1,  2,   1, 0};
        v[6] = '{1,  3,  0, 1,  1,  2,   0, 1};
        v[7] = '{2,  2,  1, 2,  2,  4,   1, 1};
        v[8] = '{15, 255, -1, 15, 255, 270, 255, 0};

        #12;
        chk_reset_outs("reset");
        @(negedge clk); reset_n = 1;
        repeat (3) @(negedge clk);
        chk("idle busy", int'(busy), 0);
        chk("idle dut_reset_n", int'(dut_reset_n), 0);

        for (int i = 0; i < 9; i++)
            run_seq($sformatf("v%0d", i), v[i].h, v[i].r, v[i].ab,
                    v[i].e_hl, v[i].e_cl, v[i].e_lat, v[i].e_cnt, v[i].e_ab);

        // abort in DONE is ignored and results are held
        @(negedge clk); abort = 1;
        repeat (2) @(negedge clk);
        abort = 0;
        chk("done abort ignored done", int'(done), 1);
        chk("done abort ignored aborted", int'(aborted), 0);
        chk("done abort ignored count", int'(cycle_count), 255);

        // start and abort together in DONE: start wins
        run_cycles = CW'(2); hold_cycles = HW'(1); start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        @(negedge clk);
        chk("start+abort busy", int'(busy), 1);
        chk("start+abort aborted", int'(aborted), 0);
        repeat (3) @(negedge clk);
        chk("start+abort done", int'(done), 1);
        chk("start+abort count", int'(cycle_count), 2);

        // reset mid-RUN, then the synchroniser delays acceptance by two edges
        hold_cycles = HW'(1); run_cycles = CW'(10); start = 1;
        @(posedge clk); #1 start = 0;
        repeat (4) @(negedge clk);
        chk("pre-reset running", int'(dut_clk_en), 1);
        #2 reset_n = 0;
        #1 chk_reset_outs("async reset");
        @(negedge clk);
        hold_cycles = HW'(2); run_cycles = CW'(3); start = 1; reset_n = 1;
        @(negedge clk); chk("sync edge1 busy", int'(busy), 0);
        @(negedge clk); chk("sync edge2 busy", int'(busy), 0);
        @(negedge clk); chk("sync edge3 busy", int'(busy), 1);
        start = 0;
        repeat (5) @(negedge clk);
        chk("post-reset done", int'(done), 1);
        chk("post-reset count", int'(cycle_count), 3);

        // after a reset with no start, nothing runs
        reset_n = 0; #3 reset_n = 1;
        repeat (6) @(negedge clk);
        chk("no start busy", int'(busy), 0);
        chk("no start done", int'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
